// File: rtl/audio_sample_pacer.sv
// Sample-rate pacer: buffers 8-bit unsigned PCM in a small FIFO and strobes one
// volume-scaled 16-bit signed sample per DIV sysclock cycles.
//
// state | meaning
// IDLE  | disabled; FIFO flushed, divider held at 0, input not accepted
// PRIME | accepting samples, no ticks until FIFO is half full
// PLAY  | divider running; each tick pops one sample (or flags underrun)
module audio_sample_pacer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SAMPLE_HZ  = 8_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sysclock,
    input  logic                          sysreset,
    input  logic                          enable,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    volume,
    output logic [15:0]                   out_sample,
    output logic                          out_valid,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t               state;
    logic [DW-1:0]        div_cnt;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic [7:0]           mem [FIFO_DEPTH];
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic signed [15:0]   head_word;
    logic signed [15:0]   head_conv;

    // Full FIFO never accepts, even when a pop happens the same cycle.
    assign in_ready   = (state != IDLE) && (level != LW'(FIFO_DEPTH));
    assign fifo_level = level;
    assign tick       = (state == PLAY) && (div_cnt == DW'(DIV - 1));
    assign push       = in_valid && in_ready;
    assign pop        = tick && (level != '0);

    // Offset-binary to two's complement, left-justified, then attenuated.
    assign head_word  = {~mem[rd_ptr][7], mem[rd_ptr][6:0], 8'h00};
    assign head_conv  = head_word >>> volume;

    always_ff @(posedge sysclock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge sysclock or negedge sysreset) begin
        if (!sysreset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            div_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            out_valid <= tick;
            if (tick) begin
                if (pop) begin
                    out_sample <= head_conv;
                end else begin
                    out_sample <= '0;
                    underrun   <= 1'b1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    state <= PRIME;
                end
                PRIME: begin
                    if (level >= LW'(FIFO_DEPTH / 2)) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_audio_sample_pacer;
    localparam int CLK_HZ    = 16;
    localparam int SAMPLE_HZ = 4;
    localparam int DEPTH     = 4;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;

    logic        sysclock = 1'b0;
    logic        sysreset = 1'b0;
    logic        enable   = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  volume   = 3'd0;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;

    audio_sample_pacer #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sysclock   (sysclock),
        .sysreset   (sysreset),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .volume     (volume),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 sysclock = ~sysclock;

    // Reference model: mode 0=stopped, 1=filling, 2=playing.
    logic [7:0]  q[$];
    int          m_mode = 0;
    int          m_cnt  = 0;
    logic [15:0] m_out  = 16'h0000;
    bit          m_ov   = 1'b0;
    bit          m_ur   = 1'b0;

    function automatic logic [15:0] conv(input logic [7:0] d, input logic [2:0] vol);
        int v;
        v = (int'(d) - 128) * 256;
        return 16'(v >>> vol);
    endfunction

    always @(posedge sysclock or negedge sysreset) begin
        int lvl0;
        bit tk;
        bit pu;
        if (!sysreset || !enable) begin
            q.delete();
            m_mode = 0;
            m_cnt  = 0;
            m_out  = 16'h0000;
            m_ov   = 1'b0;
            m_ur   = 1'b0;
        end else begin
            lvl0 = q.size();
            pu   = in_valid && (m_mode != 0) && (lvl0 < DEPTH);
            tk   = (m_mode == 2) && (m_cnt == DIV - 1);
            m_ov = tk;
            if (tk) begin
                if (lvl0 > 0) begin
                    m_out = conv(q.pop_front(), volume);
                end else begin
                    m_out = 16'h0000;
                    m_ur  = 1'b1;
                end
            end
            if (pu) q.push_back(in_data);
            if (m_mode == 2) m_cnt = (m_cnt + 1) % DIV;
            else if (m_mode == 1 && lvl0 >= DEPTH / 2) m_mode = 2;
            else if (m_mode == 0) m_mode = 1;
        end
    end

    always @(negedge sysclock) begin
        bit          e_rdy;
        logic [2:0]  e_lvl;
        e_rdy = (m_mode != 0) && (q.size() < DEPTH);
        e_lvl = 3'(q.size());
        n_vec++;
        if (in_ready !== e_rdy || fifo_level !== e_lvl || out_valid !== m_ov ||
            out_sample !== m_out || underrun !== m_ur) begin
            n_err++;
            $display("FAIL model t=%0t: got rdy=%b lvl=%0d ov=%b smp=%h ur=%b want rdy=%b lvl=%0d ov=%b smp=%h ur=%b",
                     $time, in_ready, fifo_level, out_valid, out_sample, underrun,
                     e_rdy, e_lvl, m_ov, m_out, m_ur);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge sysclock);
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 20);
        if (out_valid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no out_valid want strobe within 20 cycles", name);
        end
    endtask

    task automatic check_strobe(input string name, input logic [15:0] exp);
        int cyc;
        wait_valid(name, cyc);
        check(name, out_sample, exp);
    endtask

    task automatic push_one(input logic [7:0] v);
        @(negedge sysclock);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge sysclock);
        in_valid = 1'b0;
    endtask

    task automatic stop_play();
        enable   = 1'b0;
        in_valid = 1'b0;
        @(negedge sysclock);
        @(negedge sysclock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  vals [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [15:0] exps [8] = '{16'h8100, 16'hA300, 16'hC500, 16'hE700,
                              16'h0900, 16'h2B00, 16'h4D00, 16'h6F00};

    initial begin
        int cyc;
        repeat (2) @(negedge sysclock);
        check("reset_level", 16'(fifo_level), 16'h0);
        check("reset_ready", 16'(in_ready), 16'h0);
        sysreset = 1'b1;
        @(negedge sysclock);

        // Priming and basic conversion, strobes DIV apart
        enable = 1'b1;
        push_one(8'h80);
        push_one(8'hFF);
        check_strobe("silence", 16'h0000);
        wait_valid("second_strobe", cyc);
        check("strobe_spacing", 16'(cyc), 16'(DIV));
        check("full_scale", out_sample, 16'h7F00);
        stop_play();

        // Volume shifts
        volume = 3'd1;
        enable = 1'b1;
        push_one(8'h00);
        push_one(8'hFF);
        check_strobe("vol1_min", 16'hC000);
        check_strobe("vol1_max", 16'h3F80);
        stop_play();
        volume = 3'd7;
        enable = 1'b1;
        push_one(8'h00);
        push_one(8'h80);
        check_strobe("vol7_min", 16'hFF00);
        stop_play();
        volume = 3'd0;

        // Fill to full with in_valid held high
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h42;
        cyc = 0;
        do begin
            @(negedge sysclock);
            cyc++;
        end while (fifo_level !== 3'd4 && cyc < 12);
        check("full_level", 16'(fifo_level), 16'h4);
        check("full_not_ready", 16'(in_ready), 16'h0);
        @(negedge sysclock);
        check("full_hold_level", 16'(fifo_level), 16'h4);
        wait_valid("full_pop", cyc);
        check("after_pop_level", 16'(fifo_level), 16'h3);
        check("after_pop_ready", 16'(in_ready), 16'h1);
        stop_play();

        // Starvation and sticky underrun
        enable = 1'b1;
        push_one(8'h90);
        push_one(8'hA0);
        check_strobe("starve_s1", 16'h1000);
        check("no_underrun_yet", 16'(underrun), 16'h0);
        check_strobe("starve_s2", 16'h2000);
        check_strobe("starve_empty", 16'h0000);
        check("underrun_set", 16'(underrun), 16'h1);
        push_one(8'hC0);
        check_strobe("refill", 16'h4000);
        check("underrun_sticky", 16'(underrun), 16'h1);
        enable = 1'b0;
        @(negedge sysclock);
        check("underrun_cleared", 16'(underrun), 16'h0);
        check("flush_level", 16'(fifo_level), 16'h0);
        check("flush_sample", out_sample, 16'h0000);
        @(negedge sysclock);

        // Push on tick cycles at level 2, order preserved across wrap
        enable = 1'b1;
        push_one(vals[0]);
        push_one(vals[1]);
        check_strobe("order_0", exps[0]);
        in_valid = 1'b1;
        in_data  = vals[2];
        for (int k = 3; k < 8; k++) begin
            @(negedge sysclock);
            in_valid = 1'b0;
            @(negedge sysclock);
            @(negedge sysclock);
            in_valid = 1'b1;
            in_data  = vals[k];
            @(negedge sysclock);
            in_valid = 1'b0;
            check("order_tick_valid", 16'(out_valid), 16'h1);
            check("order_mid", out_sample, exps[k - 2]);
            check("pushpop_level", 16'(fifo_level), 16'h2);
            in_valid = (k < 7) ? 1'b0 : 1'b0;
        end
        check_strobe("order_6", exps[6]);
        check_strobe("order_7", exps[7]);
        stop_play();

        // Reset in PLAY with level 3
        enable   = 1'b1;
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) @(negedge sysclock);
        @(negedge sysclock);
        in_valid = 1'b0;
        check("pre_reset_level", 16'(fifo_level), 16'h3);
        #2 sysreset = 1'b0;
        #1;
        check("rst_level", 16'(fifo_level), 16'h0);
        check("rst_ready", 16'(in_ready), 16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_sample", out_sample, 16'h0000);
        check("rst_underrun", 16'(underrun), 16'h0);
        enable = 1'b0;
        @(negedge sysclock);
        sysreset = 1'b1;
        repeat (2) @(negedge sysclock);
        check("idle_not_ready", 16'(in_ready), 16'h0);
        enable = 1'b1;
        @(negedge sysclock);
        check("prime_ready", 16'(in_ready), 16'h1);
        @(negedge sysclock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
